// File: rtl/fixfloat_pkg.sv
// Shared constants for the fixed-point <-> IEEE-754 single conversion pipeline.
package fixfloat_pkg;

    localparam int FP_BIAS  = 127;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    localparam int FLG_INV  = 3;
    localparam int FLG_OVF  = 2;
    localparam int FLG_INX  = 1;
    localparam int FLG_ZERO = 0;

    typedef enum logic {
        OP_FIX2FLT = 1'b0,
        OP_FLT2FIX = 1'b1
    } op_e;

endpackage

// File: rtl/fixed_float_convert_pipe_lzd.sv
// Combinational leading-one detector: index of the highest set bit of a.
module lzd #(
    parameter int W = 32
) (
    input  logic [W-1:0]         a,
    output logic [$clog2(W)-1:0] idx,
    output logic                 all_zero
);

    localparam int IW = $clog2(W);

    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (a[i]) idx = IW'(i);
        end
    end

    assign all_zero = ~|a;

endmodule

// File: rtl/fixed_float_convert_pipe.sv
// Three-stage handshaked converter between signed fixed point and IEEE-754 single,
// with RNE rounding, saturation, status flags and a pass-through tag.
module fixed_float_convert_pipe
    import fixfloat_pkg::*;
#(
    parameter int FIX_W = 32,
    parameter int POS_W = 5,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             opcode,
    input  logic [31:0]      targetnumber,
    input  logic [POS_W-1:0] fixpointpos,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       flags
);

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------- S1: decode, magnitude, leading-one detect ----------------
    logic [FIX_W-1:0] fx, fmag;
    logic [POS_W-1:0] lead;
    logic             allz;
    logic             bad_pos;

    assign fx      = targetnumber[FIX_W-1:0];
    assign fmag    = fx[FIX_W-1] ? -fx : fx;
    assign bad_pos = int'(fixpointpos) >= FIX_W;

    lzd #(.W(FIX_W)) u_lzd (
        .a        (fmag),
        .idx      (lead),
        .all_zero (allz)
    );

    logic                s1_valid;
    op_e                 s1_op;
    logic                s1_sign, s1_bad, s1_allz;
    logic [FIX_W-1:0]    s1_mag;
    logic [POS_W-1:0]    s1_lead, s1_fp;
    logic [FP_EXP_W-1:0] s1_fe;
    logic [FP_MAN_W-1:0] s1_ff;
    logic [TAG_W-1:0]    s1_tag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_FIX2FLT;
            s1_sign  <= 1'b0;
            s1_bad   <= 1'b0;
            s1_allz  <= 1'b0;
            s1_mag   <= '0;
            s1_lead  <= '0;
            s1_fp    <= '0;
            s1_fe    <= '0;
            s1_ff    <= '0;
            s1_tag   <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_op    <= op_e'(opcode);
            s1_sign  <= (op_e'(opcode) == OP_FLT2FIX) ? targetnumber[31] : fx[FIX_W-1];
            s1_bad   <= bad_pos;
            s1_allz  <= allz;
            s1_mag   <= fmag;
            s1_lead  <= lead;
            s1_fp    <= fixpointpos;
            s1_fe    <= targetnumber[30:23];
            s1_ff    <= targetnumber[22:0];
            s1_tag   <= in_tag;
        end
    end

    // ---------------- S2: barrel shift and normalise ----------------
    // Fixed path left-aligns |X| in 32 bits so the leading one lands on bit 31.
    // Float path places 1.F with its integer bit at q[32]; after the shift
    // q[63:32] is the truncated integer and q[31:0] the discarded fraction.
    logic [31:0]        m32, n32;
    logic [4:0]         nsh;
    logic [7:0]         fexp;
    logic signed [9:0]  e;
    logic [63:0]        q0, q;

    assign m32  = 32'(s1_mag) << (32 - FIX_W);
    assign nsh  = 5'(FIX_W - 1) - 5'(s1_lead);
    assign n32  = m32 << nsh;
    assign fexp = 8'(FP_BIAS) + 8'(s1_lead) - 8'(s1_fp);
    assign e    = $signed(10'(s1_fe)) - $signed(10'(FP_BIAS)) + $signed(10'(s1_fp));
    assign q0   = {31'b0, 1'b1, s1_ff, 9'b0};
    assign q    = q0 << e[4:0];

    logic             s2_valid;
    op_e              s2_op;
    logic             s2_sign, s2_bad, s2_allz;
    logic [7:0]       s2_exp;
    logic [31:0]      s2_bits;
    logic             s2_sticky;
    logic             s2_nan, s2_inf, s2_den, s2_fnz, s2_big, s2_neg, s2_min;
    logic [TAG_W-1:0] s2_tag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid  <= 1'b0;
            s2_op     <= OP_FIX2FLT;
            s2_sign   <= 1'b0;
            s2_bad    <= 1'b0;
            s2_allz   <= 1'b0;
            s2_exp    <= '0;
            s2_bits   <= '0;
            s2_sticky <= 1'b0;
            s2_nan    <= 1'b0;
            s2_inf    <= 1'b0;
            s2_den    <= 1'b0;
            s2_fnz    <= 1'b0;
            s2_big    <= 1'b0;
            s2_neg    <= 1'b0;
            s2_min    <= 1'b0;
            s2_tag    <= '0;
        end else if (adv) begin
            s2_valid  <= s1_valid;
            s2_op     <= s1_op;
            s2_sign   <= s1_sign;
            s2_bad    <= s1_bad;
            s2_allz   <= s1_allz;
            s2_exp    <= fexp;
            s2_bits   <= (s1_op == OP_FIX2FLT) ? n32 : q[63:32];
            s2_sticky <= |q[31:0];
            s2_nan    <= (s1_fe == 8'hFF) && (s1_ff != '0);
            s2_inf    <= (s1_fe == 8'hFF) && (s1_ff == '0);
            s2_den    <= (s1_fe == 8'h00);
            s2_fnz    <= (s1_ff != '0);
            s2_big    <= e >= $signed(10'(FIX_W - 1));
            s2_neg    <= e < $signed(10'd0);
            s2_min    <= s1_sign && (e == $signed(10'(FIX_W - 1))) && (s1_ff == '0);
            s2_tag    <= s1_tag;
        end
    end

    // ---------------- S3: round, saturate, pack ----------------
    function automatic logic [31:0] sext(input logic [FIX_W-1:0] v);
        return 32'($signed(v));
    endfunction

    logic [FIX_W-1:0]    smax, smin, ival;
    logic [FP_MAN_W-1:0] frac;
    logic                rg, rs, rup;
    logic [FP_MAN_W:0]   rsum;
    logic [7:0]          rexp;
    logic [31:0]         res_d;
    logic [3:0]          flg_d;

    assign smax = {1'b0, {(FIX_W-1){1'b1}}};
    assign smin = {1'b1, {(FIX_W-1){1'b0}}};
    assign ival = s2_bits[FIX_W-1:0];
    assign frac = s2_bits[30:8];
    assign rg   = s2_bits[7];
    assign rs   = |s2_bits[6:0];
    assign rup  = rg & (rs | frac[0]);
    assign rsum = {1'b0, frac} + 24'(rup);
    assign rexp = s2_exp + 8'(rsum[FP_MAN_W]);

    always_comb begin
        res_d = '0;
        flg_d = '0;
        if (s2_bad) begin
            flg_d[FLG_INV] = 1'b1;
        end else if (s2_op == OP_FIX2FLT) begin
            if (s2_allz) begin
                flg_d[FLG_ZERO] = 1'b1;
            end else begin
                res_d          = {s2_sign, rexp, rsum[FP_MAN_W-1:0]};
                flg_d[FLG_INX] = rg | rs;
            end
        end else if (s2_nan) begin
            flg_d[FLG_INV] = 1'b1;
        end else if (s2_inf) begin
            res_d          = sext(s2_sign ? smin : smax);
            flg_d[FLG_OVF] = 1'b1;
        end else if (s2_den) begin
            flg_d[FLG_ZERO] = 1'b1;
            flg_d[FLG_INX]  = s2_fnz;
        end else if (s2_neg) begin
            flg_d[FLG_ZERO] = 1'b1;
            flg_d[FLG_INX]  = 1'b1;
        end else if (s2_min) begin
            // -2^(FIX_W-1) is exactly representable, so it is not an overflow
            res_d = sext(smin);
        end else if (s2_big) begin
            res_d          = sext(s2_sign ? smin : smax);
            flg_d[FLG_OVF] = 1'b1;
        end else begin
            res_d           = sext(s2_sign ? -ival : ival);
            flg_d[FLG_INX]  = s2_sticky;
            flg_d[FLG_ZERO] = (ival == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            out_tag   <= '0;
            flags     <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                result  <= res_d;
                out_tag <= s2_tag;
                flags   <= flg_d;
            end
        end
    end

endmodule
